// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multiply/divide sequencer owning the HI/LO registers
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

    state_t               state_q;
    logic [5:0]           cnt_q;
    // Shared accumulator: mul = {partial product, multiplier}, div = {remainder, quotient}
    logic [2*WIDTH-1:0]   acc_q;
    // Multiplicand for mul, divisor for div
    logic [WIDTH-1:0]     mcand_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    logic [WIDTH:0]       rem_ext;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_acc;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;

    // Operand magnitudes for signed ops, and one iteration of each datapath
    always_comb begin
        a_neg    = md_op[0] & src_a[WIDTH-1];
        b_neg    = md_op[0] & src_b[WIDTH-1];
        mag_a    = a_neg ? (~src_a + WIDTH'(1)) : src_a;
        mag_b    = b_neg ? (~src_b + WIDTH'(1)) : src_b;

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder shifted left with the next dividend bit; one extra bit guards the trial subtract
        rem_ext  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = {1'b0, rem_ext} - {2'b00, mcand_q};
        if (!div_diff[WIDTH+1]) begin
            div_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        acc_d    = (state_q == S_DIV) ? div_acc : mul_acc;

        prod_fix = neg_quo_q ? (~mul_acc + (2*WIDTH)'(1)) : mul_acc;
        quo_fix  = neg_quo_q ? (~div_acc[WIDTH-1:0] + WIDTH'(1)) : div_acc[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (~div_acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : div_acc[2*WIDTH-1:WIDTH];

        hi_d     = (state_q == S_DIV) ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = (state_q == S_DIV) ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Sequencer FSM: accept, iterate one bit per cycle, commit HI/LO, pulse done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        acc_q     <= {{WIDTH{1'b0}}, mag_a};
                        mcand_q   <= mag_b;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= 6'd0;
                        state_q   <= md_op[1] ? S_DIV : S_MUL;
                    end else if (!start && !flush) begin
                        if (hi_we) begin
                            hi_q <= wdata;
                        end
                        if (lo_we) begin
                            lo_q <= wdata;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == LAST_CNT) begin
                            hi_q    <= hi_d;
                            lo_q    <= lo_d;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Hold the pipeline while a request is being accepted or iterating
    assign stall = ((state_q == S_IDLE) && start) || (state_q == S_MUL) || (state_q == S_DIV);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[8];

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on magnitudes, then sign fix
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic        sgn;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] p;
        sgn = op[0];
        ma  = (sgn && a[31]) ? 32'(0 - a) : a;
        mb  = (sgn && b[31]) ? 32'(0 - b) : b;
        if (!op[1]) begin
            p = 64'(ma) * 64'(mb);
            if (sgn && (a[31] ^ b[31])) p = 64'(0) - p;
            eh = p[63:32];
            el = p[31:0];
        end else begin
            if (mb == 0) begin
                q = 32'hFFFF_FFFF;
                r = ma;
            end else begin
                q = ma / mb;
                r = ma % mb;
            end
            if (sgn && (a[31] ^ b[31])) q = 32'(0 - q);
            if (sgn && a[31]) r = 32'(0 - r);
            eh = r;
            el = q;
        end
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int stall_cnt;
        int done_cyc;
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        #1;
        stall_cnt = stall ? 1 : 0;
        done_cyc  = -1;
        for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            src_a = $urandom; src_b = $urandom; md_op = 2'($urandom);
            #1;
            if (stall) stall_cnt++;
            if (done) done_cyc = k;
        end
        check({name, " done_cycle"}, 64'(done_cyc), 64'd33);
        check({name, " stall_cycles"}, 64'(stall_cnt), 64'd33);
        check({name, " hi"}, 64'(hi), 64'(eh));
        check({name, " lo"}, 64'(lo), 64'(el));
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40 && cyc < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) cyc = k;
        end
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        hi_we = h; lo_we = l; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        int          cyc;
        int          dcount;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5] = '{2'b10, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[6] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

        rst_n = 1'b0; start = 1'b0; md_op = 2'b00; src_a = '0; src_b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
        end

        // Flush mid-MULT keeps HI/LO and never pulses done
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        check("mt hi", 64'(hi), 64'h11);
        check("mt lo", 64'(lo), 64'h22);
        @(negedge clk);
        start = 1'b1; md_op = 2'b01; src_a = 32'd1234; src_b = 32'hFFFF_FF00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush stall", 64'(stall), 64'd0);
        dcount = done ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done) dcount++;
        end
        check("flush done pulses", 64'(dcount), 64'd0);
        check("flush hi", 64'(hi), 64'h11);
        check("flush lo", 64'(lo), 64'h22);

        // Reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; md_op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        check("midrst stall", 64'(stall), 64'd0);
        rst_n = 1'b1;

        // MTHI together with start is dropped; MTHI in idle lands on HI only
        mt(1'b0, 1'b1, 32'h55);
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234; start = 1'b1; md_op = 2'b00; src_a = 32'd2; src_b = 32'd3;
        @(negedge clk);
        hi_we = 1'b0; start = 1'b0;
        #1;
        check("mthi+start hi", 64'(hi), 64'd0);
        wait_done(cyc);
        check("mthi+start op done", 64'(cyc), 64'd32);
        check("mthi+start op hi", 64'(hi), 64'd0);
        check("mthi+start op lo", 64'(lo), 64'd6);
        mt(1'b1, 1'b0, 32'h1234);
        check("mthi idle hi", 64'(hi), 64'h1234);
        check("mthi idle lo", 64'(lo), 64'd6);

        // Back-to-back MULT: second held start is accepted the cycle after done
        @(negedge clk);
        start = 1'b1; md_op = 2'b01; src_a = 32'd5; src_b = 32'hFFFF_FFFA;
        @(negedge clk);
        wait_done(cyc);
        start = 1'b1; src_a = 32'hFFFF_FFF0; src_b = 32'hFFFF_FFF0;
        check("b2b first done", 64'(cyc), 64'd32);
        check("b2b first hi", 64'(hi), 64'hFFFF_FFFF);
        check("b2b first lo", 64'(lo), 64'hFFFF_FFE2);
        check("b2b done-cycle stall", 64'(stall), 64'd0);
        @(negedge clk);
        #1;
        check("b2b accept stall", 64'(stall), 64'd1);
        wait_done(cyc);
        check("b2b second done", 64'(cyc), 64'd33);
        check("b2b second hi", 64'(hi), 64'd0);
        check("b2b second lo", 64'(lo), 64'd256);

        // Randomized against the reference model, with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(rop, ra, rb, eh, el);
            run_op($sformatf("rnd%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb, eh, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
